// File: rtl/pipe_adder_pkg.sv
// Shared types and the segment adder used by pipe_adder.
// Optional feature macro: PIPE_ADDER_OVF_EN (signed overflow output).
package pipe_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_SEG_W = 8;
    // Widest segment the ripple helper can handle.
    localparam int unsigned MAX_SEG_W     = 128;

    typedef struct packed {
        logic                 carry;  // carry out of the segment MSB
        logic                 c_msb;  // carry into the segment MSB
        logic [MAX_SEG_W-1:0] sum;    // only the low n bits are meaningful
    } seg_res_t;

    // Ripple-add the low n bits of a_seg and b_seg with c_in.
    function automatic seg_res_t seg_add(
        input logic [MAX_SEG_W-1:0] a_seg,
        input logic [MAX_SEG_W-1:0] b_seg,
        input logic                 c_in,
        input int unsigned          n
    );
        seg_res_t r;
        logic     c;
        r = '0;
        c = c_in;
        for (int unsigned i = 0; i < MAX_SEG_W; i++) begin
            if (i < n) begin
                r.sum[i] = a_seg[i] ^ b_seg[i] ^ c;
                if (i == n - 1) begin
                    r.c_msb = c;
                end
                c = (a_seg[i] & b_seg[i]) | (a_seg[i] & c) | (b_seg[i] & c);
            end
        end
        r.carry = c;
        return r;
    endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One pipeline stage of pipe_adder: resolves segment IDX of the sum and
// forwards operands, partial sum, carry and valid to the next stage.
// Optional feature macro: PIPE_ADDER_OVF_EN.
module pipe_adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SEG_W = DEFAULT_SEG_W,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned LO = IDX * SEG_W;

    logic [MAX_SEG_W-1:0] a_ext;
    logic [MAX_SEG_W-1:0] b_ext;
    seg_res_t             res;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Segment add plus next-state selection: load on advance, hold otherwise.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[SEG_W-1:0] = a_i[LO +: SEG_W];
        b_ext[SEG_W-1:0] = b_i[LO +: SEG_W];
        res = seg_add(a_ext, b_ext, carry_i, SEG_W);

        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef PIPE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (en) begin
            valid_d = valid_i;
            a_d     = a_i;
            b_d     = b_i;
            sum_d   = sum_i;
            sum_d[LO +: SEG_W] = res.sum[SEG_W-1:0];
            carry_d = res.carry;
`ifdef PIPE_ADDER_OVF_EN
            ovf_d   = res.carry ^ res.c_msb;
`endif
        end
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef PIPE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf_o   = ovf_q;
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with valid/ready handshake. WIDTH is split into
// STAGES = WIDTH/SEG_W carry-chained segments, one register stage each.
// Optional feature macro: PIPE_ADDER_OVF_EN (adds the ovf output).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0 || SEG_W == 0 || SEG_W > MAX_SEG_W) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W (SEG_W <= MAX_SEG_W)");
    end

    logic             en;
    logic             valid_c [0:STAGES];
    logic [WIDTH-1:0] a_c     [0:STAGES];
    logic [WIDTH-1:0] b_c     [0:STAGES];
    logic [WIDTH-1:0] sum_c   [0:STAGES];
    logic             carry_c [0:STAGES];
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf_c   [1:STAGES];
`endif

    // Whole pipe advances unless the output slot is full and not taken.
    always_comb begin
        en = out_ready | ~out_valid;
    end

    assign in_ready   = en;
    assign valid_c[0] = in_valid & en;
    assign a_c[0]     = a;
    assign b_c[0]     = b ^ {WIDTH{sub}};
    assign sum_c[0]   = '0;
    assign carry_c[0] = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_seg #(
            .WIDTH (WIDTH),
            .SEG_W (SEG_W),
            .IDX   (k)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .valid_i (valid_c[k]),
            .a_i     (a_c[k]),
            .b_i     (b_c[k]),
            .sum_i   (sum_c[k]),
            .carry_i (carry_c[k]),
            .valid_o (valid_c[k+1]),
            .a_o     (a_c[k+1]),
            .b_o     (b_c[k+1]),
            .sum_o   (sum_c[k+1]),
            .carry_o (carry_c[k+1])
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf_o   (ovf_c[k+1])
`endif
        );
    end

    assign out_valid = valid_c[STAGES];
    assign sum       = sum_c[STAGES];
    assign cout      = carry_c[STAGES];
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = ovf_c[STAGES];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=32, SEG_W=8).
// Optional feature macro: PIPE_ADDER_OVF_EN (enables ovf checks).
module tb_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    pipe_adder #(
        .WIDTH (32),
        .SEG_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one add/sub, then check it is absent for 3 edges and present
    // after the 4th edge with the expected sum/cout (and ovf).
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tcin, input logic tsub,
                          input logic [31:0] esum, input logic ecout, input logic eovf);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
            step();
        end
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ecout});
`ifdef PIPE_ADDER_OVF_EN
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eovf});
`else
        if (eovf) begin end
`endif
        step();
    endtask

    initial begin
        int tx;
        int rx;
        logic [31:0] exp_q [6];

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        run_op("seg_carry",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_5m7",    32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_7m5",    32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
        run_op("sub_7m5m1",  32'd7, 32'd5, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0);
        run_op("ovf_pos",    32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_neg",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        run_op("ovf_none",   32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // Backpressure: 6 back-to-back adds, out_ready low in cycles 5..7.
        for (int i = 0; i < 6; i++) exp_q[i] = 32'(i + 1) + 32'h10;
        tx = 0; rx = 0; cin = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (tx < 6);
            a = 32'(tx + 1);
            b = 32'h10;
            #1;
            chk("bp_in_ready", {31'b0, in_ready}, {31'b0, !(cyc >= 5 && cyc <= 7)});
            chk("bp_out_valid", {31'b0, out_valid}, {31'b0, (cyc >= 4 && cyc <= 12)});
            if (out_valid && rx < 6) begin
                chk("bp_sum", sum, exp_q[rx]);
                if (out_ready) rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_rx_count", 32'(rx), 32'd6);
        chk("bp_tx_count", 32'(tx), 32'd6);

        // Reset with 3 transactions in flight (first one at the output).
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'h100 + 32'(i); b = '0;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("mid_pre_valid", {31'b0, out_valid}, 32'd1);
        chk("mid_pre_sum", sum, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_sum", sum, 32'd0);
        chk("mid_rst_cout", {31'b0, cout}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_stale", {31'b0, out_valid}, 32'd0);
            step();
        end
        run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
